pkt_out_read: RTL and testbench
===============================

Name: pkt_out_read

Overview:
- Output-side reader that consumes the packet-address stream emitted by the buffer manager.
- Dequeues 5-bit buffer handles and reads the packet words out of the cut RAM or the no-cut RAM (11-bit address = {buf[3:0], offset[6:0]}).
- Streams the words to the egress FIFO under backpressure, then returns the 4-bit buffer address to the matching recycle port so the address manager can reuse it.

Parameters:
- ADDR_FIFO_DEPTH, 32, handle FIFO depth; equals the total number of buffers (16 cut + 16 no-cut), so the FIFO cannot overflow in legal operation.
- FULL_THRESH, 8'd240, egress pkt_out_usedw level at or above which new RAM reads stall.
- MAX_WORDS, 128, words per buffer; offset wraps at 127.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- pkt_addr  in  5  buffer handle; [4]=1 cut RAM, [4]=0 no-cut RAM; [3:0]=buffer index
- pkt_addr_wr  in  1  handle strobe
- ram_rd_addr  out  11  cut RAM read address
- ram_rd  out  1  cut RAM read enable
- ram_data_q  in  139  cut RAM data, valid 1 cycle after ram_rd
- nocut_pkt_ram_rd_addr  out  11  no-cut RAM read address
- nocut_pkt_ram_rd  out  1  no-cut RAM read enable
- nocut_pkt_ram_data_q  in  139  no-cut RAM data, 1-cycle latency
- pkt_out_recycle_addr  out  4  cut buffer to free
- pkt_out_recycle_addr_wr  out  1  cut recycle strobe
- nocutpkt_out_recycle_addr  out  4  no-cut buffer to free
- nocutpkt_out_recycle_addr_wr  out  1  no-cut recycle strobe
- pkt_out_data  out  139  egress word; [138:136] 101 head / 100 middle / 110 tail; [135:132] invalid bytes; [127:0] payload
- pkt_out_valid  out  1  egress word strobe
- pkt_out_usedw  in  8  egress FIFO fill level
- addr_fifo_overflow  out  1  sticky; set on a push into a full handle FIFO
- trunc_cnt  out  16  count of packets force-terminated at MAX_WORDS (saturating)
- head_err_cnt  out  16  count of packets whose first word type is not 101 (saturating)

Behaviour:
- Reset values: all outputs 0, handle FIFO emptied, FSM in IDLE, counters 0, sticky flag cleared.
- Handle FIFO: first-word-fall-through. A push while full is dropped and sets addr_fifo_overflow.
- FSM states IDLE, READ, WAIT, RECYCLE.
  - IDLE: if the FIFO is non-empty and pkt_out_usedw < FULL_THRESH, pop the handle, latch sel=[4], buf=[3:0], offset=0, then go to READ.
  - READ: each cycle with pkt_out_usedw < FULL_THRESH, assert the rd of the selected RAM only, with address {buf, offset}, and increment offset. At or above the threshold, deassert rd and hold offset. The unselected RAM's rd stays 0.
  - The word returned one cycle after rd is registered onto pkt_out_data/pkt_out_valid. Latency from rd to pkt_out_valid is 2 cycles.
  - Tail (type 110) on the returned word: stop issuing reads that cycle. Any word returned from a read already in flight is discarded (no pkt_out_valid). Go to WAIT.
  - Word at offset 127 read with no tail: stop reads. When that word returns, force [138:136]=110, emit it, increment trunc_cnt, go to WAIT.
  - First returned word with type != 101: increment head_err_cnt; the word is still forwarded unchanged.
  - WAIT: one cycle so the discarded in-flight read drains, then go to RECYCLE.
  - RECYCLE: one-cycle pulse of the selected recycle_wr with addr=buf, then go to IDLE. Earliest next pop is the cycle after RECYCLE, so there is no back-to-back overlap.
- The FIFO accepts a push and a pop in the same cycle. On an empty FIFO, the pushed handle is poppable on the next cycle.
- Reset mid-packet: reads abort and no recycle is issued for the in-flight buffer. The buffer manager's own reset restores its free list.
- A backpressure stall in READ never loses a word. Words already in flight are still emitted, and FULL_THRESH leaves at least 2 words of egress headroom.

Decomposition:
- Shared package holds:
  - word-type constants TYPE_HEAD=3'b101, TYPE_MID=3'b100, TYPE_TAIL=3'b110
  - field positions for type, invalid-bytes and payload
  - BUF_IDX_W=4, OFFSET_W=7
  - the FSM state encoding
- One sub-module: pkt_addr_fifo (5-bit wide, depth ADDR_FIFO_DEPTH, FWFT, with full/empty/overflow).

Test Plan:
- Push handle 5'b1_0011; cut RAM holds 3 words (101, 100, 110) at 0x180-0x182 -> ram_rd_addr 0x180..0x182 (plus at most one speculative 0x183); 3 pkt_out_valid pulses, the first 2 cycles after the first ram_rd; pkt_out_recycle_addr_wr pulse with value 3; nocut_pkt_ram_rd stays 0 throughout.
- Push 5'b0_0111 with a 1-word packet (head and tail in one word, typed 110) -> exactly 1 output word; nocutpkt_out_recycle_addr=7 pulsed once; cut recycle strobe stays 0.
- Hold pkt_out_usedw=240 for 10 cycles mid-packet -> reads stop within 1 cycle; no word lost or duplicated; output resumes in order when usedw drops to 100.
- No-tail buffer (128 middle words) -> 128 output words; the last word has type 110; trunc_cnt=1; recycle issued.
- Push 33 handles with pkt_out_usedw held at 255 -> addr_fifo_overflow=1; the 33rd handle is dropped; release -> 32 packets emitted in push order.
- Assert reset during READ of handle 5'b1_0001 -> all outputs 0 the next cycle; no recycle strobe for buffer 1; the FIFO is empty after reset.

Source files
------------

// File: rtl/pkt_out_read_pkg.sv
// pkt_out_read_pkg: shared word-format, geometry and FSM definitions for the egress reader
package pkt_out_read_pkg;
    localparam int DATA_W    = 139;
    localparam int TYPE_HI   = 138;
    localparam int TYPE_LO   = 136;
    localparam int INV_HI    = 135;
    localparam int INV_LO    = 132;
    localparam int PAY_HI    = 127;
    localparam int PAY_LO    = 0;
    localparam int BUF_IDX_W = 4;
    localparam int OFFSET_W  = 7;
    localparam int HANDLE_W  = BUF_IDX_W + 1;
    localparam int RAM_AW    = BUF_IDX_W + OFFSET_W;
    localparam int CNT_W     = 16;

    localparam logic [2:0] TYPE_HEAD = 3'b101;
    localparam logic [2:0] TYPE_MID  = 3'b100;
    localparam logic [2:0] TYPE_TAIL = 3'b110;

    typedef enum logic [1:0] {IDLE, READ, WAIT, RECYCLE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/pkt_out_read_addr_fifo.sv
// pkt_addr_fifo: first-word-fall-through handle queue; pushes into a full queue are dropped and flagged
module pkt_addr_fifo
    import pkt_out_read_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HANDLE_W-1:0] din,
    input  logic                push,
    input  logic                pop,
    output logic [HANDLE_W-1:0] dout,
    output logic                full,
    output logic                empty,
    output logic                overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [HANDLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       cnt;
    logic                do_push;
    logic                do_pop;

    always_comb begin
        full    = cnt == CW'(DEPTH);
        empty   = cnt == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            cnt    <= cnt + CW'(do_push) - CW'(do_pop);
            if (push && full) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/pkt_out_read.sv
// pkt_out_read: dequeues buffer handles, streams the buffer's words from cut/no-cut RAM to egress, then frees the buffer
module pkt_out_read
    import pkt_out_read_pkg::*;
#(
    parameter int         ADDR_FIFO_DEPTH = 32,
    parameter logic [7:0] FULL_THRESH     = 8'd240,
    parameter int         MAX_WORDS       = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [HANDLE_W-1:0]  pkt_addr,
    input  logic                 pkt_addr_wr,
    output logic [RAM_AW-1:0]    ram_rd_addr,
    output logic                 ram_rd,
    input  logic [DATA_W-1:0]    ram_data_q,
    output logic [RAM_AW-1:0]    nocut_pkt_ram_rd_addr,
    output logic                 nocut_pkt_ram_rd,
    input  logic [DATA_W-1:0]    nocut_pkt_ram_data_q,
    output logic [BUF_IDX_W-1:0] pkt_out_recycle_addr,
    output logic                 pkt_out_recycle_addr_wr,
    output logic [BUF_IDX_W-1:0] nocutpkt_out_recycle_addr,
    output logic                 nocutpkt_out_recycle_addr_wr,
    output logic [DATA_W-1:0]    pkt_out_data,
    output logic                 pkt_out_valid,
    input  logic [7:0]           pkt_out_usedw,
    output logic                 addr_fifo_overflow,
    output logic [CNT_W-1:0]     trunc_cnt,
    output logic [CNT_W-1:0]     head_err_cnt
);
    localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(MAX_WORDS - 1);

    state_t                state, state_nx;
    logic                  sel;
    logic [BUF_IDX_W-1:0]  buf_idx;
    logic [OFFSET_W-1:0]   offset;
    logic                  done, first, rd_d, last_d;
    logic [HANDLE_W-1:0]   head;
    logic                  full, empty, pop, stall, rd, ret, ret_tail, ret_last, recycle;
    logic [DATA_W-1:0]     ret_word;

    pkt_addr_fifo #(.DEPTH(ADDR_FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .din      (pkt_addr),
        .push     (pkt_addr_wr),
        .pop      (pop),
        .dout     (head),
        .full     (full),
        .empty    (empty),
        .overflow (addr_fifo_overflow)
    );

    // A returning tail kills the read of the same cycle, so nothing beyond the tail is fetched
    always_comb begin
        stall    = pkt_out_usedw >= FULL_THRESH;
        ret_word = sel ? ram_data_q : nocut_pkt_ram_data_q;
        ret      = state == READ && rd_d;
        ret_tail = ret && ret_word[TYPE_HI:TYPE_LO] == TYPE_TAIL;
        ret_last = ret && last_d;
        rd       = state == READ && !stall && !done && !ret_tail;
        pop      = state == IDLE && !empty && !stall;
        recycle  = state == RECYCLE;
        state_nx = state == IDLE ? (pop ? READ : IDLE) :
                   state == READ ? ((ret_tail || ret_last) ? WAIT : READ) :
                   state == WAIT ? RECYCLE : IDLE;
    end

    assign ram_rd                       = rd && sel;
    assign nocut_pkt_ram_rd             = rd && !sel;
    assign ram_rd_addr                  = sel ? {buf_idx, offset} : '0;
    assign nocut_pkt_ram_rd_addr        = sel ? '0 : {buf_idx, offset};
    assign pkt_out_recycle_addr_wr      = recycle && sel;
    assign nocutpkt_out_recycle_addr_wr = recycle && !sel;
    assign pkt_out_recycle_addr         = (recycle && sel) ? buf_idx : '0;
    assign nocutpkt_out_recycle_addr    = (recycle && !sel) ? buf_idx : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sel           <= 1'b0;
            buf_idx       <= '0;
            offset        <= '0;
            done          <= 1'b0;
            first         <= 1'b0;
            rd_d          <= 1'b0;
            last_d        <= 1'b0;
            pkt_out_data  <= '0;
            pkt_out_valid <= 1'b0;
            trunc_cnt     <= '0;
            head_err_cnt  <= '0;
        end else begin
            state         <= state_nx;
            rd_d          <= rd;
            last_d        <= rd && offset == LAST_OFF;
            pkt_out_valid <= ret;
            if (ret) pkt_out_data <= ret_last ? {TYPE_TAIL, ret_word[INV_HI:0]} : ret_word;
            if (pop) begin
                sel     <= head[HANDLE_W-1];
                buf_idx <= head[BUF_IDX_W-1:0];
                offset  <= '0;
                done    <= 1'b0;
                first   <= 1'b1;
            end else if (rd) begin
                offset <= offset + 1'b1;
                if (offset == LAST_OFF) done <= 1'b1;
            end
            if (ret) first <= 1'b0;
            if (ret && first && ret_word[TYPE_HI:TYPE_LO] != TYPE_HEAD) head_err_cnt <= sat_inc(head_err_cnt);
            if (ret_last && !ret_tail) trunc_cnt <= sat_inc(trunc_cnt);
        end
    end
endmodule

// File: tb/tb_pkt_out_read.sv
// tb_pkt_out_read: table-driven packet vectors plus overflow and mid-packet reset sequences
module tb_pkt_out_read;
    import pkt_out_read_pkg::*;

    typedef struct {
        logic [4:0]  h;
        int          len;
        int          stall_at;
        int          exp_words;
        logic [15:0] exp_trunc;
        logic [15:0] exp_herr;
        logic [2:0]  exp_last;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [4:0]   pkt_addr = '0;
    logic         pkt_addr_wr = 1'b0;
    logic [10:0]  ram_rd_addr, nocut_pkt_ram_rd_addr;
    logic         ram_rd, nocut_pkt_ram_rd;
    logic [138:0] ram_data_q = '0;
    logic [138:0] nocut_pkt_ram_data_q = '0;
    logic [3:0]   pkt_out_recycle_addr, nocutpkt_out_recycle_addr;
    logic         pkt_out_recycle_addr_wr, nocutpkt_out_recycle_addr_wr;
    logic [138:0] pkt_out_data;
    logic         pkt_out_valid;
    logic [7:0]   pkt_out_usedw = '0;
    logic         addr_fifo_overflow;
    logic [15:0]  trunc_cnt, head_err_cnt;

    pkt_out_read dut (
        .clk(clk), .reset(reset), .pkt_addr(pkt_addr), .pkt_addr_wr(pkt_addr_wr),
        .ram_rd_addr(ram_rd_addr), .ram_rd(ram_rd), .ram_data_q(ram_data_q),
        .nocut_pkt_ram_rd_addr(nocut_pkt_ram_rd_addr), .nocut_pkt_ram_rd(nocut_pkt_ram_rd),
        .nocut_pkt_ram_data_q(nocut_pkt_ram_data_q),
        .pkt_out_recycle_addr(pkt_out_recycle_addr), .pkt_out_recycle_addr_wr(pkt_out_recycle_addr_wr),
        .nocutpkt_out_recycle_addr(nocutpkt_out_recycle_addr),
        .nocutpkt_out_recycle_addr_wr(nocutpkt_out_recycle_addr_wr),
        .pkt_out_data(pkt_out_data), .pkt_out_valid(pkt_out_valid), .pkt_out_usedw(pkt_out_usedw),
        .addr_fifo_overflow(addr_fifo_overflow), .trunc_cnt(trunc_cnt), .head_err_cnt(head_err_cnt)
    );

    always #5 clk = ~clk;

    logic [138:0] cut_mem [2048];
    logic [138:0] nocut_mem [2048];
    always @(posedge clk) begin
        if (ram_rd) ram_data_q <= cut_mem[ram_rd_addr];
        if (nocut_pkt_ram_rd) nocut_pkt_ram_data_q <= nocut_mem[nocut_pkt_ram_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [138:0] out_q[$];
    int           out_cyc[$];
    logic [12:0]  rd_q[$];
    int           rd_cyc[$];
    logic [4:0]   rec_q[$];
    int           stall_rd = 0;
    int           both_rd = 0;
    always @(negedge clk) if (!reset) begin
        if (pkt_out_valid) begin
            out_q.push_back(pkt_out_data);
            out_cyc.push_back(cyc);
        end
        if (ram_rd || nocut_pkt_ram_rd) begin
            rd_q.push_back({ram_rd, nocut_pkt_ram_rd, ram_rd ? ram_rd_addr : nocut_pkt_ram_rd_addr});
            rd_cyc.push_back(cyc);
            if (pkt_out_usedw >= 8'd240) stall_rd++;
        end
        if (ram_rd && nocut_pkt_ram_rd) both_rd++;
        if (pkt_out_recycle_addr_wr) rec_q.push_back({1'b1, pkt_out_recycle_addr});
        if (nocutpkt_out_recycle_addr_wr) rec_q.push_back({1'b0, nocutpkt_out_recycle_addr});
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [138:0] got, input logic [138:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [138:0] mk_word(input logic [2:0] t, input logic [4:0] h, input int k);
        return {t, 4'(k), 4'h0, 104'h0, 3'b0, h, 8'(k), 8'hA5};
    endfunction

    function automatic logic [2:0] stored_type(input int len, input int k);
        if (len == 0) return TYPE_MID;
        if (k == len - 1) return TYPE_TAIL;
        return (k == 0) ? TYPE_HEAD : TYPE_MID;
    endfunction

    function automatic logic [138:0] exp_word(input logic [4:0] h, input int len, input int k);
        if (len == 0 && k == 127) return mk_word(TYPE_TAIL, h, k);
        return mk_word(stored_type(len, k), h, k);
    endfunction

    task automatic load_pkt(input logic [4:0] h, input int len);
        for (int k = 0; k < 128; k++) begin
            if (h[4]) cut_mem[{h[3:0], 7'(k)}] = mk_word(stored_type(len, k), h, k);
            else nocut_mem[{h[3:0], 7'(k)}] = mk_word(stored_type(len, k), h, k);
        end
    endtask

    task automatic push(input logic [4:0] h);
        pkt_addr = h;
        pkt_addr_wr = 1'b1;
        @(posedge clk); #1;
        pkt_addr_wr = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, pkt_out_data, '0);
        check({tag, "_strobes"}, {ram_rd, nocut_pkt_ram_rd, pkt_out_valid, pkt_out_recycle_addr_wr,
              nocutpkt_out_recycle_addr_wr, addr_fifo_overflow}, '0);
        check({tag, "_addrs"}, {ram_rd_addr, nocut_pkt_ram_rd_addr, pkt_out_recycle_addr, nocutpkt_out_recycle_addr}, '0);
        check({tag, "_counters"}, {trunc_cnt, head_err_cnt}, '0);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int o0, r0, c0, s0, t, n, nr, k, stall_left, hi;
        bit stalled;
        logic [138:0] w;
        logic [12:0] er;
        load_pkt(v.h, v.len);
        o0 = out_q.size(); r0 = rd_q.size(); c0 = rec_q.size(); s0 = stall_rd;
        push(v.h);
        t = 0; stalled = 0; stall_left = 0;
        while (rec_q.size() == c0 && t < 1000) begin
            @(posedge clk); #1; t++;
            if (v.stall_at >= 0 && !stalled && out_q.size() - o0 >= v.stall_at) begin
                pkt_out_usedw = 8'd240; stalled = 1; stall_left = 10;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) pkt_out_usedw = 8'd100;
            end
        end
        check($sformatf("v%0d_recycle_timeout", i), t < 1000, 1'b1);
        repeat (4) @(posedge clk);
        #1 pkt_out_usedw = 8'd0;
        n = out_q.size() - o0;
        nr = rd_q.size() - r0;
        check($sformatf("v%0d_word_count", i), n, v.exp_words);
        if (n > 0) begin
            k = n - 1;
            for (int j = n - 1; j >= 0; j--) if (out_q[o0+j] !== exp_word(v.h, v.len, j)) k = j;
            check($sformatf("v%0d_word%0d", i, k), out_q[o0+k], exp_word(v.h, v.len, k));
            w = out_q[o0+n-1];
            check($sformatf("v%0d_last_type", i), w[138:136], v.exp_last);
            if (nr > 0) check($sformatf("v%0d_rd_to_valid_latency", i), out_cyc[o0] - rd_cyc[r0], 2);
        end
        hi = (v.exp_words < 128) ? v.exp_words + 1 : 128;
        check($sformatf("v%0d_read_count_%0d_in_range", i, nr), nr >= v.exp_words && nr <= hi, 1'b1);
        if (nr > 0) begin
            k = 0;
            for (int j = nr - 1; j >= 0; j--) begin
                er = {v.h[4], !v.h[4], v.h[3:0], 7'(j)};
                if (rd_q[r0+j] !== er) k = j;
            end
            check($sformatf("v%0d_read%0d_ram_addr", i, k), rd_q[r0+k], {v.h[4], !v.h[4], v.h[3:0], 7'(k)});
        end
        check($sformatf("v%0d_recycle_count", i), rec_q.size() - c0, 1);
        if (rec_q.size() > c0) check($sformatf("v%0d_recycle_handle", i), rec_q[c0], v.h);
        check($sformatf("v%0d_reads_while_stalled", i), stall_rd - s0, 0);
        check($sformatf("v%0d_trunc_cnt", i), trunc_cnt, v.exp_trunc);
        check($sformatf("v%0d_head_err_cnt", i), head_err_cnt, v.exp_herr);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int o0, r0, c0, t, k, n;
        logic [138:0] ew;
        vt[0] = '{5'b1_0011,   3, -1,   3, 16'd0, 16'd0, TYPE_TAIL};
        vt[1] = '{5'b0_0111,   1, -1,   1, 16'd0, 16'd1, TYPE_TAIL};
        vt[2] = '{5'b1_0101,  20,  5,  20, 16'd0, 16'd1, TYPE_TAIL};
        vt[3] = '{5'b0_0010,   0, -1, 128, 16'd1, 16'd2, TYPE_TAIL};
        vt[4] = '{5'b0_1111,   2, -1,   2, 16'd1, 16'd2, TYPE_TAIL};
        vt[5] = '{5'b1_0000, 128, 40, 128, 16'd1, 16'd2, TYPE_TAIL};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_idle_outputs("reset");

        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);
        check("both_rams_read_together", both_rd, 0);

        // 33 pushes while egress is full: the last one must be dropped
        pkt_out_usedw = 8'd255;
        for (int h = 0; h < 32; h++) load_pkt(5'(h), 2);
        o0 = out_q.size(); r0 = rd_q.size(); c0 = rec_q.size();
        for (int h = 0; h < 32; h++) push(5'(h));
        push(5'h05);
        repeat (3) @(posedge clk);
        #1 check("ovf_flag_set", addr_fifo_overflow, 1'b1);
        check("ovf_no_reads_while_full", rd_q.size() - r0, 0);
        pkt_out_usedw = 8'd0;
        t = 0;
        while (rec_q.size() - c0 < 32 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        check("ovf_drain_timeout", t < 3000, 1'b1);
        repeat (20) @(posedge clk);
        #1 check("ovf_recycle_count", rec_q.size() - c0, 32);
        n = rec_q.size() - c0;
        if (n > 0) begin
            k = 0;
            for (int j = n - 1; j >= 0; j--) if (rec_q[c0+j] !== 5'(j)) k = j;
            check($sformatf("ovf_recycle_order%0d", k), rec_q[c0+k], 5'(k));
        end
        n = out_q.size() - o0;
        check("ovf_word_count", n, 64);
        if (n > 0) begin
            k = 0;
            for (int j = n - 1; j >= 0; j--) if (out_q[o0+j] !== exp_word(5'(j / 2), 2, j % 2)) k = j;
            ew = exp_word(5'(k / 2), 2, k % 2);
            check($sformatf("ovf_word%0d", k), out_q[o0+k], ew);
        end
        check("ovf_flag_sticky", addr_fifo_overflow, 1'b1);
        check("ovf_head_err_unchanged", head_err_cnt, 16'd2);

        // reset in the middle of reading cut buffer 1 with another handle queued behind it
        load_pkt(5'b1_0001, 30);
        load_pkt(5'b0_0010, 3);
        r0 = rd_q.size(); c0 = rec_q.size();
        push(5'b1_0001);
        push(5'b0_0010);
        t = 0;
        while (rd_q.size() - r0 < 4 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("rst_reads_started", t < 100, 1'b1);
        check("rst_in_read", ram_rd, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 check_idle_outputs("rst_mid");
        reset = 1'b0;
        o0 = out_q.size(); r0 = rd_q.size();
        repeat (30) @(posedge clk);
        #1 check("rst_no_reads_after", rd_q.size() - r0, 0);
        check("rst_no_words_after", out_q.size() - o0, 0);
        check("rst_no_recycle", rec_q.size() - c0, 0);
        check_idle_outputs("rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
